// File: rtl/eth_status_counters_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_stats_pkg
// Description : Shared constants for the Ethernet MAC status counters:
//               status_vector bit positions, default event count and a
//               legality check for the read-address width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package eth_stats_pkg;

    // Bit positions of the MAC status_vector as wired onto event_in.
    localparam int TX_FIFO_OVERFLOW   = 0;
    localparam int TX_FIFO_BAD_FRAME  = 1;
    localparam int TX_FIFO_GOOD_FRAME = 2;
    localparam int TX_ERROR_UNDERFLOW = 3;
    localparam int RX_ERROR_BAD_FRAME = 4;
    localparam int RX_ERROR_BAD_FCS   = 5;
    localparam int RX_FIFO_OVERFLOW   = 6;
    localparam int RX_FIFO_BAD_FRAME  = 7;
    localparam int RX_FIFO_GOOD_FRAME = 8;

    localparam int NUM_MAC_EVENTS     = 9;

    // True when the event count is in range and every counter index is
    // reachable through the read address.
    function automatic bit addr_width_ok(input int addr_width, input int num_events);
        return (num_events >= 1) && (num_events <= 32) &&
               ((64'd1 << addr_width) >= 64'(num_events));
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_status_counters_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_status_counters_if
// Description : Valid/ready read port of the status counter block.
// Ports       : rd_req_valid/rd_req_ready/rd_addr     - request channel
//               rd_resp_valid/rd_resp_ready/rd_resp_data/rd_resp_error
//                                                      - response channel
//               modport master : reader side
//               modport slave  : counter block side
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_status_counters_if
    import eth_stats_pkg::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int COUNTER_WIDTH = 32
);
    logic                     rd_req_valid;
    logic                     rd_req_ready;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic                     rd_resp_valid;
    logic                     rd_resp_ready;
    logic [COUNTER_WIDTH-1:0] rd_resp_data;
    logic                     rd_resp_error;

    modport master (
        output rd_req_valid, rd_addr, rd_resp_ready,
        input  rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_error
    );

    modport slave (
        input  rd_req_valid, rd_addr, rd_resp_ready,
        output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_error
    );
endinterface
`default_nettype wire

// File: rtl/eth_status_counters_counter.sv
`default_nettype none
// ============================================================================
// Module      : eth_stat_counter
// Description : One statistics lane: live counter, shadow copy, sticky
//               overflow and event-seen flags, saturate/wrap and clear.
// Ports       : clock, reset        - clock, async active-high reset
//               event_in            - count enable for this cycle
//               snapshot            - copy live value to shadow
//               snapshot_clear      - with snapshot: restart the interval
//               shadow              - last snapshot value
//               overflow            - sticky overflow flag (live)
//               event_seen          - sticky event flag (live)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_stat_counter
    import eth_stats_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter bit SATURATE      = 1'b1
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     event_in,
    input  wire logic                     snapshot,
    input  wire logic                     snapshot_clear,
    output logic      [COUNTER_WIDTH-1:0] shadow,
    output logic                          overflow,
    output logic                          event_seen
);
    localparam logic [COUNTER_WIDTH-1:0] C_ALL_ONES = '1;

    logic [COUNTER_WIDTH-1:0] r_live;
    logic [COUNTER_WIDTH-1:0] r_shadow;
    logic                     r_overflow;
    logic                     r_seen;
    logic                     w_clear;
    logic                     w_at_max;

    assign w_clear  = snapshot && snapshot_clear;
    assign w_at_max = (r_live == C_ALL_ONES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_live     <= '0;
            r_shadow   <= '0;
            r_overflow <= 1'b0;
            r_seen     <= 1'b0;
        end else begin
            // Shadow takes the pre-update value: this cycle's event is not in it.
            if (snapshot) begin
                r_shadow <= r_live;
            end
            if (w_clear) begin
                // The event of the clearing cycle opens the new interval.
                r_live     <= {{(COUNTER_WIDTH-1){1'b0}}, event_in};
                r_overflow <= 1'b0;
                r_seen     <= event_in;
            end else if (event_in) begin
                r_seen <= 1'b1;
                if (w_at_max) begin
                    r_overflow <= 1'b1;
                    if (!SATURATE) begin
                        r_live <= '0;
                    end
                end else begin
                    r_live <= r_live + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    assign shadow     = r_shadow;
    assign overflow   = r_overflow;
    assign event_seen = r_seen;

endmodule
`default_nettype wire

// File: rtl/eth_status_counters.sv
`default_nettype none
// ============================================================================
// Module      : eth_status_counters
// Description : Per-event statistics collector for the MAC status pulses.
//               NUM_EVENTS live counters with an atomic shadow bank, read
//               back through a single-entry valid/ready response register.
// Ports       : clock, reset        - 125 MHz clock, async active-high reset
//               event_in            - one count per high cycle per bit
//               snapshot            - copy live counters to shadow bank
//               snapshot_clear      - with snapshot: zero live counters/flags
//               rd                  - read port (eth_status_counters_if.slave)
//               overflow            - sticky overflow flags
//               event_seen          - sticky event-seen flags
// Revision    : 1.0 - initial release
// ============================================================================
module eth_status_counters
    import eth_stats_pkg::*;
#(
    parameter int NUM_EVENTS    = NUM_MAC_EVENTS,
    parameter int COUNTER_WIDTH = 32,
    parameter bit SATURATE      = 1'b1,
    parameter int ADDR_WIDTH    = 5
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic [NUM_EVENTS-1:0] event_in,
    input  wire logic                  snapshot,
    input  wire logic                  snapshot_clear,
    eth_status_counters_if.slave       rd,
    output logic      [NUM_EVENTS-1:0] overflow,
    output logic      [NUM_EVENTS-1:0] event_seen
);
    if (!addr_width_ok(ADDR_WIDTH, NUM_EVENTS)) begin : g_param_check
        $error("eth_status_counters: illegal NUM_EVENTS/ADDR_WIDTH combination");
    end

    logic [COUNTER_WIDTH-1:0] w_shadow [NUM_EVENTS];
    logic [COUNTER_WIDTH-1:0] w_rd_data;
    logic                     w_rd_hit;
    logic                     w_req_fire;

    logic                     r_resp_valid;
    logic [COUNTER_WIDTH-1:0] r_resp_data;
    logic                     r_resp_error;

    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_counter
        eth_stat_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .SATURATE      (SATURATE)
        ) u_counter (
            .clock          (clock),
            .reset          (reset),
            .event_in       (event_in[gi]),
            .snapshot       (snapshot),
            .snapshot_clear (snapshot_clear),
            .shadow         (w_shadow[gi]),
            .overflow       (overflow[gi]),
            .event_seen     (event_seen[gi])
        );
    end

    // Shadow read mux; an address that matches no counter reads as zero
    // and is flagged as an error.
    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd.rd_addr == ADDR_WIDTH'(i)) begin
                w_rd_data = w_shadow[i];
                w_rd_hit  = 1'b1;
            end
        end
    end

    // The response slot can take a new request when empty or being drained.
    assign rd.rd_req_ready = !r_resp_valid || rd.rd_resp_ready;
    assign w_req_fire      = rd.rd_req_valid && rd.rd_req_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
        end else if (w_req_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_rd_data;
            r_resp_error <= !w_rd_hit;
        end else if (rd.rd_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign rd.rd_resp_valid = r_resp_valid;
    assign rd.rd_resp_data  = r_resp_data;
    assign rd.rd_resp_error = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_eth_status_counters.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_status_counters
// Description : Self-checking bench for eth_status_counters. Two 8-bit
//               instances (saturating and wrapping) share one stimulus and
//               are compared every cycle against an event-total model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_status_counters;
    import eth_stats_pkg::*;

    localparam int NE = 9;
    localparam int CW = 8;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NE-1:0] event_in;
    logic          snapshot;
    logic          snapshot_clear;
    logic          rd_req_valid;
    logic [AW-1:0] rd_addr;
    logic          rd_resp_ready;
    logic [NE-1:0] ovf0, ovf1, seen0, seen1;

    int vectors     = 0;
    int miscompares = 0;

    always #4 clock = ~clock;

    eth_status_counters_if #(.ADDR_WIDTH(AW), .COUNTER_WIDTH(CW)) rd0 ();
    eth_status_counters_if #(.ADDR_WIDTH(AW), .COUNTER_WIDTH(CW)) rd1 ();

    assign rd0.rd_req_valid  = rd_req_valid;
    assign rd0.rd_addr       = rd_addr;
    assign rd0.rd_resp_ready = rd_resp_ready;
    assign rd1.rd_req_valid  = rd_req_valid;
    assign rd1.rd_addr       = rd_addr;
    assign rd1.rd_resp_ready = rd_resp_ready;

    eth_status_counters #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .SATURATE(1'b1), .ADDR_WIDTH(AW)) dut_sat (
        .clock(clock), .reset(reset), .event_in(event_in), .snapshot(snapshot),
        .snapshot_clear(snapshot_clear), .rd(rd0), .overflow(ovf0), .event_seen(seen0)
    );

    eth_status_counters #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .SATURATE(1'b0), .ADDR_WIDTH(AW)) dut_wrap (
        .clock(clock), .reset(reset), .event_in(event_in), .snapshot(snapshot),
        .snapshot_clear(snapshot_clear), .rd(rd1), .overflow(ovf1), .event_seen(seen1)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [CW-1:0] exp_sat(input longint t);
        return (t > 255) ? 8'hFF : 8'(t);
    endfunction

    function automatic logic [CW-1:0] exp_wrap(input longint t);
        return 8'(t % 256);
    endfunction

    // ---------------- behavioural model ----------------
    // Each counter is tracked as the total number of events in the current
    // interval; the saturating and wrapping views are derived from it.
    longint tot [NE];
    longint sh  [NE];
    bit     seen_m [NE];
    bit     m_valid;
    bit     m_err;
    longint m_tot;
    bit     m_rr;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                tot[i] = 0; sh[i] = 0; seen_m[i] = 0;
            end
            m_valid = 0; m_err = 0; m_tot = 0;
        end else begin
            m_rr = !m_valid || rd_resp_ready;
            if (rd_req_valid && m_rr) begin
                m_valid = 1;
                if (int'(rd_addr) < NE) begin
                    m_err = 0; m_tot = sh[rd_addr];
                end else begin
                    m_err = 1; m_tot = 0;
                end
            end else if (rd_resp_ready) begin
                m_valid = 0;
            end
            if (snapshot) begin
                for (int i = 0; i < NE; i++) sh[i] = tot[i];
            end
            for (int i = 0; i < NE; i++) begin
                if (snapshot && snapshot_clear) begin
                    tot[i] = longint'(event_in[i]);
                    seen_m[i] = event_in[i];
                end else if (event_in[i]) begin
                    tot[i] = tot[i] + 1;
                    seen_m[i] = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NE-1:0] m_ovf_v, m_seen_v;

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NE; i++) begin
                m_ovf_v[i]  = (tot[i] >= 256);
                m_seen_v[i] = seen_m[i];
            end
            chk("sat.resp_valid",  rd0.rd_resp_valid, m_valid);
            chk("wrap.resp_valid", rd1.rd_resp_valid, m_valid);
            chk("sat.req_ready",   rd0.rd_req_ready, !m_valid || rd_resp_ready);
            chk("wrap.req_ready",  rd1.rd_req_ready, !m_valid || rd_resp_ready);
            chk("sat.overflow",    ovf0, m_ovf_v);
            chk("wrap.overflow",   ovf1, m_ovf_v);
            chk("sat.event_seen",  seen0, m_seen_v);
            chk("wrap.event_seen", seen1, m_seen_v);
            if (m_valid) begin
                chk("sat.resp_data",   rd0.rd_resp_data, exp_sat(m_tot));
                chk("wrap.resp_data",  rd1.rd_resp_data, exp_wrap(m_tot));
                chk("sat.resp_error",  rd0.rd_resp_error, m_err);
                chk("wrap.resp_error", rd1.rd_resp_error, m_err);
            end
        end
    end

    // ---------------- response collector ----------------
    typedef struct {
        logic [CW-1:0] d0;
        logic [CW-1:0] d1;
        logic          e0;
        logic          e1;
    } rsp_t;

    rsp_t rsp_q[$];
    rsp_t col_r;

    always @(negedge clock) begin
        if (!reset && rd0.rd_resp_valid && rd_resp_ready) begin
            col_r.d0 = rd0.rd_resp_data;
            col_r.d1 = rd1.rd_resp_data;
            col_r.e0 = rd0.rd_resp_error;
            col_r.e1 = rd1.rd_resp_error;
            rsp_q.push_back(col_r);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_snapshot(input bit clr);
        snapshot = 1'b1;
        snapshot_clear = clr;
        step();
        snapshot = 1'b0;
        snapshot_clear = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        bit ok;
        ok = 0;
        rd_req_valid = 1'b1;
        rd_addr = a;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (rd0.rd_req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("read_accept");
        @(posedge clock);
        #1;
        rd_req_valid = 1'b0;
    endtask

    task automatic get_resp(output rsp_t r);
        for (int k = 0; k < 100 && rsp_q.size() == 0; k++) @(negedge clock);
        if (rsp_q.size() == 0) begin
            timeout_fail("read_response");
            r.d0 = '0; r.d1 = '0; r.e0 = 1'b0; r.e1 = 1'b0;
        end else begin
            r = rsp_q.pop_front();
        end
    endtask

    task automatic read_expect(input logic [AW-1:0] a, input logic [CW-1:0] e_sat,
                               input logic [CW-1:0] e_wrap, input logic e_err);
        rsp_t r;
        rsp_q.delete();
        issue_read(a);
        get_resp(r);
        chk("lit.sat_data",  r.d0, e_sat);
        chk("lit.wrap_data", r.d1, e_wrap);
        chk("lit.error",     r.e0, e_err);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rsp_t r;
        event_in = '0; snapshot = 1'b0; snapshot_clear = 1'b0;
        rd_req_valid = 1'b0; rd_addr = '0; rd_resp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst.resp_valid", rd0.rd_resp_valid, 1'b0);
        chk("rst.req_ready",  rd0.rd_req_ready, 1'b1);
        chk("rst.resp_data",  rd0.rd_resp_data, 8'h00);
        chk("rst.resp_error", rd0.rd_resp_error, 1'b0);
        chk("rst.overflow",   ovf0, 9'h000);
        chk("rst.event_seen", seen1, 9'h000);
        reset = 1'b0;
        step();

        // Five events on bit 2, snapshot, read back
        event_in = 9'h004;
        repeat (5) step();
        event_in = '0;
        pulse_snapshot(1'b0);
        read_expect(5'd2, 8'd5, 8'd5, 1'b0);
        @(negedge clock);
        chk("t1.event_seen", seen0, 9'h004);
        step();

        // 300 consecutive events on bit 0: saturate vs wrap
        pulse_snapshot(1'b1);
        event_in = 9'h001;
        repeat (300) step();
        event_in = '0;
        pulse_snapshot(1'b0);
        read_expect(5'd0, 8'd255, 8'd44, 1'b0);
        @(negedge clock);
        chk("t2.sat_overflow0",  ovf0[0], 1'b1);
        chk("t2.wrap_overflow0", ovf1[0], 1'b1);
        step();

        // Event in the clearing snapshot cycle goes into the new interval
        pulse_snapshot(1'b1);
        event_in = 9'h010;
        repeat (10) step();
        snapshot = 1'b1; snapshot_clear = 1'b1;
        step();
        snapshot = 1'b0; snapshot_clear = 1'b0; event_in = '0;
        read_expect(5'd4, 8'd10, 8'd10, 1'b0);
        @(negedge clock);
        chk("t3.overflow",   ovf0, 9'h000);
        chk("t3.event_seen", seen0, 9'h010);
        step();
        pulse_snapshot(1'b0);
        read_expect(5'd4, 8'd1, 8'd1, 1'b0);

        // Back-to-back reads with a stalled response
        event_in = 9'h001; step();
        event_in = 9'h002; repeat (2) step();
        event_in = 9'h004; repeat (3) step();
        event_in = '0;
        pulse_snapshot(1'b0);
        repeat (2) step();
        rsp_q.delete();
        rd_resp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_addr = 5'd0;
        step();
        rd_addr = 5'd1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            chk("t4.stall_req_ready", rd0.rd_req_ready, 1'b0);
            chk("t4.stall_valid",     rd0.rd_resp_valid, 1'b1);
            chk("t4.stall_data",      rd0.rd_resp_data, 8'd1);
            @(posedge clock); #1;
        end
        rd_resp_ready = 1'b1;
        issue_read(5'd1);
        issue_read(5'd2);
        for (int s = 0; s < 3; s++) begin
            get_resp(r);
            chk("t4.stream_sat",  r.d0, 8'(s + 1));
            chk("t4.stream_wrap", r.d1, 8'(s + 1));
        end

        // Out-of-range address, then a normal one
        event_in = 9'h100;
        repeat (3) step();
        event_in = '0;
        pulse_snapshot(1'b0);
        rsp_q.delete();
        issue_read(5'd12);
        issue_read(5'd8);
        get_resp(r);
        chk("t5.oob_data",  r.d0, 8'd0);
        chk("t5.oob_error", r.e0, 1'b1);
        chk("t5.oob_error_wrap", r.e1, 1'b1);
        get_resp(r);
        chk("t5.addr8_data",  r.d0, 8'd3);
        chk("t5.addr8_error", r.e0, 1'b0);

        // Randomised traffic checked by the model
        for (int c = 0; c < 1500; c++) begin
            event_in       = NE'($urandom) | NE'($urandom);
            snapshot       = ($urandom_range(0, 39) == 0);
            snapshot_clear = ($urandom_range(0, 9) == 0);
            rd_req_valid   = ($urandom_range(0, 1) == 1);
            rd_addr        = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 8));
            rd_resp_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        event_in = '0; snapshot = 1'b0; snapshot_clear = 1'b0;
        rd_req_valid = 1'b0; rd_resp_ready = 1'b1;
        repeat (3) step();

        // Reset while a response is pending
        event_in = '1;
        repeat (5) step();
        event_in = '0;
        pulse_snapshot(1'b0);
        rd_resp_ready = 1'b0;
        issue_read(5'd3);
        @(negedge clock);
        chk("t6.pending_valid", rd0.rd_resp_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6.async_valid_sat",  rd0.rd_resp_valid, 1'b0);
        chk("t6.async_valid_wrap", rd1.rd_resp_valid, 1'b0);
        chk("t6.async_overflow",   ovf0, 9'h000);
        chk("t6.async_seen",       seen0, 9'h000);
        repeat (2) step();
        reset = 1'b0;
        rd_resp_ready = 1'b1;
        step();
        pulse_snapshot(1'b0);
        for (int a = 0; a < NE; a++) begin
            read_expect(AW'(a), 8'd0, 8'd0, 1'b0);
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
